mem_fetch_master: RTL and testbench



---
 rtl/fetch_pkg.sv | 26 ++
 rtl/mem_fetch_master_if.sv | 52 +++++
 rtl/word_unpacker.sv | 52 +++++
 rtl/mem_fetch_master.sv | 168 ++++++++++++++++
 tb/tb_mem_fetch_master.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the ROM fetch master.
//               Holds the FSM state encoding (also shown on LEDR[2:0]),
//               the number of bytes per ROM word and the default run length.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int BYTES_PER_WORD    = 8;
  localparam int DEFAULT_NUM_WORDS = 9;

  // Encodings are visible on the board LEDs, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_REQ    = 3'b001,
    ST_WAIT   = 3'b010,
    ST_UNPACK = 3'b011,
    ST_DONE   = 3'b101,
    ST_ERR    = 3'b110
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_fetch_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_fetch_master_if
// Description : Bundles the Avalon-MM read bus towards mem_wrapper and the
//               byte-FIFO write side towards the MAC lanes.
// Signals     : avm_address/avm_read      - read request (master drives)
//               avm_readdata/avm_readdatavalid/avm_waitrequest - responder
//               byte_data/byte_wr         - byte and one-hot FIFO strobe
//               fifo_full                 - per-FIFO full flags
// Modports    : master (fetch engine), slave (memory + FIFO side)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_fetch_master_if
  import fetch_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int DATA_W    = 64
);

  logic [31:0]          avm_address;
  logic                 avm_read;
  logic [DATA_W-1:0]    avm_readdata;
  logic                 avm_readdatavalid;
  logic                 avm_waitrequest;
  logic [7:0]           byte_data;
  logic [NUM_WORDS-1:0] byte_wr;
  logic [NUM_WORDS-1:0] fifo_full;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_readdatavalid,
    input  avm_waitrequest,
    output byte_data,
    output byte_wr,
    input  fifo_full
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_readdatavalid,
    output avm_waitrequest,
    input  byte_data,
    input  byte_wr,
    output fifo_full
  );

endinterface
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : word_unpacker
// Description : Holds one ROM word and presents it MSB-first, one byte at a
//               time. load captures a word and restarts the byte count;
//               advance shifts the next byte up; last flags the final byte.
// Ports       : CLOCK_50, reset_n (async, active-low)
//               load, load_data  - capture a new word
//               advance          - current byte consumed, move to next
//               byte_out         - current byte (word[63:56] after load)
//               last             - current byte is the eighth of the word
// Revision    : 1.0 - initial release
// ============================================================================
module word_unpacker
  import fetch_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              advance,
  output logic [7:0]        byte_out,
  output logic              last
);

  localparam int                 c_CNT_W   = $clog2(BYTES_PER_WORD);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(BYTES_PER_WORD - 1);

  logic [DATA_W-1:0]  r_shreg;
  logic [c_CNT_W-1:0] r_byte_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else if (load) begin
      r_shreg    <= load_data;
      r_byte_cnt <= '0;
    end else if (advance) begin
      r_shreg    <= {r_shreg[DATA_W-9:0], 8'h00};
      r_byte_cnt <= r_byte_cnt + c_CNT_ONE;
    end
  end

  assign byte_out = r_shreg[DATA_W-1 -: 8];
  assign last     = (r_byte_cnt == c_CNT_END);

endmodule
`default_nettype wire

// File: rtl/mem_fetch_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_fetch_master
// Description : Avalon-MM read initiator. Fetches NUM_WORDS 64-bit words
//               from BASE_ADDR upward (rows first, vector last), one read
//               outstanding at a time, and writes each word MSB-first as
//               eight bytes into FIFO number word_cnt.
// Ports       : CLOCK_50, reset_n (async, active-low)
//               start            - begins a run from IDLE/DONE/ERR
//               busy/done/error  - status (REQ/WAIT/UNPACK, DONE, ERR)
//               state_o          - raw state encoding for LEDR[2:0]
//               bus (master)     - Avalon read bus + byte FIFO write side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fetch_master
  import fetch_pkg::*;
#(
  parameter int          NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          TIMEOUT   = 64,
  parameter int          DATA_W    = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_o,
  mem_fetch_master_if.master bus
);

  localparam int                c_WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int                c_TM_W      = $clog2(TIMEOUT + 1);
  localparam logic [c_WC_W-1:0] c_LAST_WORD = c_WC_W'(NUM_WORDS - 1);
  localparam logic [c_WC_W-1:0] c_WC_ONE    = c_WC_W'(1);
  localparam logic [c_TM_W-1:0] c_TM_LAST   = c_TM_W'(TIMEOUT - 1);
  localparam logic [c_TM_W-1:0] c_TM_ONE    = c_TM_W'(1);

  fetch_state_t      r_state,       w_state_nxt;
  logic              r_avm_read,    w_avm_read_nxt;
  logic [31:0]       r_avm_address, w_avm_address_nxt;
  logic [c_WC_W-1:0] r_word_cnt,    w_word_cnt_nxt;
  logic [c_TM_W-1:0] r_timer,       w_timer_nxt;

  logic              w_load;
  logic              w_advance;
  logic              w_last;
  logic              w_fifo_full;
  logic [7:0]        w_byte;

  // --------------------------------------------------------------------------
  // Byte unpacker
  // --------------------------------------------------------------------------
  word_unpacker #(
    .DATA_W (DATA_W)
  ) u_unpacker (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_data (bus.avm_readdata),
    .advance   (w_advance),
    .byte_out  (w_byte),
    .last      (w_last)
  );

  // A byte leaves every UNPACK cycle the target FIFO has room; the same
  // condition both strobes the FIFO and shifts the unpacker.
  assign w_fifo_full = bus.fifo_full[r_word_cnt];
  assign w_advance   = (r_state == ST_UNPACK) && !w_fifo_full;

  generate
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_byte_wr
      assign bus.byte_wr[g] = w_advance && (r_word_cnt == c_WC_W'(g));
    end
  endgenerate

  assign bus.byte_data   = w_byte;
  assign bus.avm_read    = r_avm_read;
  assign bus.avm_address = r_avm_address;

  assign busy    = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_UNPACK);
  assign done    = (r_state == ST_DONE);
  assign error   = (r_state == ST_ERR);
  assign state_o = r_state;

  // --------------------------------------------------------------------------
  // FSM state and bus registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_avm_read    <= 1'b0;
      r_avm_address <= BASE_ADDR;
      r_word_cnt    <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_avm_read    <= w_avm_read_nxt;
      r_avm_address <= w_avm_address_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_timer       <= w_timer_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_avm_read_nxt    = r_avm_read;
    w_avm_address_nxt = r_avm_address;
    w_word_cnt_nxt    = r_word_cnt;
    w_timer_nxt       = r_timer;
    w_load            = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nxt       = ST_REQ;
          w_word_cnt_nxt    = '0;
          w_avm_address_nxt = BASE_ADDR;
          w_avm_read_nxt    = 1'b1;
        end
      end

      ST_REQ: begin
        // Request stays asserted with a stable address until accepted.
        if (r_avm_read && !bus.avm_waitrequest) begin
          w_avm_read_nxt = 1'b0;
          w_timer_nxt    = '0;
          w_state_nxt    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_timer_nxt = r_timer + c_TM_ONE;
        // Data arriving on the timeout cycle still counts as a good read.
        if (bus.avm_readdatavalid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_UNPACK;
        end else if (r_timer == c_TM_LAST) begin
          w_state_nxt = ST_ERR;
        end
      end

      ST_UNPACK: begin
        if (w_advance && w_last) begin
          if (r_word_cnt == c_LAST_WORD) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_word_cnt_nxt    = r_word_cnt + c_WC_ONE;
            w_avm_address_nxt = r_avm_address + 32'd1;
            w_avm_read_nxt    = 1'b1;
            w_state_nxt       = ST_REQ;
          end
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_avm_read_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_fetch_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fetch_master
// Description : Self-checking bench for mem_fetch_master. A responder models
//               the 10-cycle mem_wrapper ROM (word a = bytes a1..a8), while
//               scoreboard queues hold the expected read addresses and the
//               expected (FIFO, byte) writes in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fetch_master;
  import fetch_pkg::*;

  localparam int c_NW  = 9;
  localparam int c_LAT = 10;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, done, error;
  logic [2:0] state_o;

  mem_fetch_master_if #(.NUM_WORDS(c_NW), .DATA_W(64)) bus ();

  mem_fetch_master #(
    .NUM_WORDS (c_NW),
    .BASE_ADDR (32'd0),
    .TIMEOUT   (64),
    .DATA_W    (64)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .state_o  (state_o),
    .bus      (bus.master)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] exp_q[$];       // {fifo index, byte}
  logic [31:0] exp_addr_q[$];
  logic [7:0]  got0[$];
  logic [7:0]  got8[$];
  bit          capture  = 1'b0;
  bit          no_resp  = 1'b0;
  bit          spur_req = 1'b0;
  int          wr_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rom_word(input logic [31:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 1; k <= 8; k++) w[(8-k)*8 +: 8] = {a[3:0], 4'(k)};
    return w;
  endfunction

  task automatic push_run();
    for (int r = 0; r < c_NW; r++) begin
      exp_addr_q.push_back(32'(r));
      for (int k = 1; k <= 8; k++) exp_q.push_back({4'(r), 4'(r), 4'(k)});
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_read(input logic lvl, input string name);
    int n;
    n = 0;
    while (bus.avm_read !== lvl && n < 100) begin step(); n++; end
    check(name, 64'(bus.avm_read), 64'(lvl));
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin step(); n++; end
    check(name, 64'(done), 64'd1);
  endtask

  // --------------------------------------------------------------------------
  // Responder: mem_wrapper model driven on the falling edge
  // --------------------------------------------------------------------------
  initial begin : responder
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    cnt  = 0;
    pend_addr = '0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      bus.avm_readdatavalid = 1'b0;
      if (!reset_n) pend = 1'b0;
      if (pend && cnt == 0) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = rom_word(pend_addr);
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
      end else if (spur_req) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
        spur_req = 1'b0;
      end
      if (wr_stall > 0 && bus.avm_read) begin
        bus.avm_waitrequest = 1'b1;
        wr_stall--;
      end else begin
        bus.avm_waitrequest = 1'b0;
      end
      if (reset_n && bus.avm_read && !bus.avm_waitrequest) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_addr: unexpected read of %0h", bus.avm_address);
        end else begin
          check("rd_addr", 64'(bus.avm_address), 64'(exp_addr_q.pop_front()));
        end
        if (!no_resp) begin
          pend      = 1'b1;
          cnt       = c_LAT - 1;
          pend_addr = bus.avm_address;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte monitor: pops the expected write each time a strobe is seen
  // --------------------------------------------------------------------------
  initial begin : byte_monitor
    logic [3:0]  idx;
    logic [11:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (bus.byte_wr !== '0) begin
        idx = '0;
        for (int i = 0; i < c_NW; i++) if (bus.byte_wr[i]) idx = 4'(i);
        check("byte_wr_onehot", 64'($countones(bus.byte_wr)), 64'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL byte_wr: unexpected write %0h to fifo %0d", bus.byte_data, idx);
        end else begin
          e = exp_q.pop_front();
          check("byte_fifo", 64'(idx), 64'(e[11:8]));
          check("byte_data", 64'(bus.byte_data), 64'(e[7:0]));
        end
        if (capture && idx == 4'd0) got0.push_back(bus.byte_data);
        if (capture && idx == 4'd8) got8.push_back(bus.byte_data);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin : main
    int   n;
    int   dot;
    logic [31:0] addr0;

    reset_n       = 1'b0;
    start         = 1'b0;
    bus.fifo_full = '0;
    repeat (3) step();

    check("rst_state", 64'(state_o), 64'(3'b000));
    check("rst_read", 64'(bus.avm_read), 64'd0);
    check("rst_addr", 64'(bus.avm_address), 64'd0);
    check("rst_byte_wr", 64'(bus.byte_wr), 64'd0);
    check("rst_byte_data", 64'(bus.byte_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset_n = 1'b1;
    step();

    // Spurious readdatavalid while IDLE
    spur_req = 1'b1;
    repeat (3) step();
    check("spur_idle_state", 64'(state_o), 64'(3'b000));

    // Run 1: nominal, full speed
    push_run();
    capture = 1'b1;
    pulse_start();
    wait_done("run1_done", n);
    check("run1_cycles_le_250", 64'(n <= 250), 64'd1);
    check("run1_state", 64'(state_o), 64'(3'b101));
    check("run1_busy", 64'(busy), 64'd0);
    check("run1_bytes_left", 64'(exp_q.size()), 64'd0);
    check("run1_addr_left", 64'(exp_addr_q.size()), 64'd0);
    capture = 1'b0;
    dot = 0;
    for (int k = 0; k < 8; k++)
      if (k < got0.size() && k < got8.size()) dot += int'(got0[k]) * int'(got8[k]);
    check("dot_lane0", 64'(dot), 64'h12CC);
    repeat (3) step();
    check("done_hold", 64'(state_o), 64'(3'b101));

    // Run 2: waitrequest stall, spurious data in REQ, FIFO 3 backpressure
    push_run();
    wr_stall = 5;
    pulse_start();
    wait_read(1'b1, "run2_read_up");
    addr0    = bus.avm_address;
    spur_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wreq_read_held", 64'(bus.avm_read), 64'd1);
      check("wreq_addr_held", 64'(bus.avm_address), 64'(addr0));
      check("wreq_state_req", 64'(state_o), 64'(3'b001));
    end
    step();
    check("wreq_read_drop", 64'(bus.avm_read), 64'd0);
    check("wreq_state_wait", 64'(state_o), 64'(3'b010));

    n = 0;
    while (bus.byte_wr[3] !== 1'b1 && n < 400) begin step(); n++; end
    check("run2_word3_seen", 64'(bus.byte_wr[3]), 64'd1);
    bus.fifo_full[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("full_no_wr", 64'(bus.byte_wr), 64'd0);
      check("full_byte_held", 64'(bus.byte_data), 64'h31);
      step();
    end
    bus.fifo_full[3] = 1'b0;
    wait_done("run2_done", n);
    check("run2_bytes_left", 64'(exp_q.size()), 64'd0);

    // Timeout: responder accepts but never returns data
    no_resp = 1'b1;
    exp_addr_q.push_back(32'd0);
    pulse_start();
    wait_read(1'b0, "to_accepted");
    n = 0;
    while (error !== 1'b1 && n < 200) begin step(); n++; end
    check("to_wait_cycles", 64'(n), 64'd64);
    check("to_state", 64'(state_o), 64'(3'b110));
    check("to_error", 64'(error), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    repeat (3) step();
    check("err_hold", 64'(state_o), 64'(3'b110));
    no_resp = 1'b0;

    // Recovery after error
    push_run();
    pulse_start();
    wait_done("recover_done", n);
    check("recover_bytes_left", 64'(exp_q.size()), 64'd0);

    // Reset during UNPACK of word 5, then refetch everything
    push_run();
    pulse_start();
    n = 0;
    while (bus.byte_wr[5] !== 1'b1 && n < 400) begin step(); n++; end
    check("rst_mid_word5_seen", 64'(bus.byte_wr[5]), 64'd1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_byte_wr", 64'(bus.byte_wr), 64'd0);
    check("rst_mid_read", 64'(bus.avm_read), 64'd0);
    check("rst_mid_state", 64'(state_o), 64'(3'b000));
    check("rst_mid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
    push_run();
    pulse_start();
    wait_done("refetch_done", n);
    check("refetch_bytes_left", 64'(exp_q.size()), 64'd0);
    check("refetch_addr_left", 64'(exp_addr_q.size()), 64'd0);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
